// File: rtl/rope_segment_core.sv
// One segment of a token-scheduled rope: NODE_CONTAINS nodes relaxed one at a time toward their neighbours.
// Optional macro ROPE_TRACE_EN prints per-edge token and node state; behaviour is identical without it.
module rope_segment_core #(
    parameter int NODE_CONTAINS = 5,
    parameter int CORE_ID       = 1,
    parameter int SPACING       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [31:0]           prev_core_last_x,
    input  logic signed [31:0]           prev_core_last_y,
    input  logic signed [31:0]           next_core_first_x,
    input  logic signed [31:0]           next_core_first_y,
    input  logic signed [31:0]           x_mouse,
    input  logic signed [31:0]           y_mouse,
    output logic [NODE_CONTAINS*32-1:0]  pos_x,
    output logic [NODE_CONTAINS*32-1:0]  pos_y,
    output logic [2*NODE_CONTAINS-1:0]   control_signal
);

    localparam int TW = 2 * NODE_CONTAINS;

    logic [TW-1:0] token;

    // Weighted average (p + 2c + n) / 4 with floor rounding; 34 bits keeps the sum exact.
    function automatic logic signed [31:0] constrain(
        input logic signed [31:0] p,
        input logic signed [31:0] c,
        input logic signed [31:0] n
    );
        logic signed [33:0] sum;
        logic signed [33:0] shifted;
        sum     = $signed({{2{p[31]}}, p}) + $signed({c[31], c, 1'b0}) + $signed({{2{n[31]}}, n});
        shifted = sum >>> 2;
        return shifted[31:0];
    endfunction

    // NOTE: all state uses non-blocking assignments so every node sees neighbour values from before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            token <= TW'(1);
        end else begin
            token <= {token[TW-2:0], token[TW-1]};
        end
    end

    assign control_signal = token;

    for (genvar i = 0; i < NODE_CONTAINS; i++) begin : g_node
        localparam logic signed [31:0] RESET_X = 32'(((CORE_ID - 1) * NODE_CONTAINS + i) * SPACING);
        localparam bit HEAD = (i == 0) && (CORE_ID == 1);

        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] px;
        logic signed [31:0] py;
        logic signed [31:0] nx;
        logic signed [31:0] ny;
        logic signed [31:0] relax_x;
        logic signed [31:0] relax_y;

        if (i == 0) begin : g_first
            assign px = prev_core_last_x;
            assign py = prev_core_last_y;
        end else begin : g_inner_prev
            assign px = pos_x[32*(i-1) +: 32];
            assign py = pos_y[32*(i-1) +: 32];
        end

        if (i == NODE_CONTAINS - 1) begin : g_last
            assign nx = next_core_first_x;
            assign ny = next_core_first_y;
        end else begin : g_inner_next
            assign nx = pos_x[32*(i+1) +: 32];
            assign ny = pos_y[32*(i+1) +: 32];
        end

        // The mouse-anchored head node is never pulled by its neighbours.
        assign relax_x = HEAD ? x : constrain(px, x, nx);
        assign relax_y = HEAD ? y : constrain(py, y, ny);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                x <= RESET_X;
                y <= '0;
            end else if (token[i]) begin
                x <= relax_x;
                y <= relax_y;
            end else if (HEAD && token[i+NODE_CONTAINS]) begin
                x <= x_mouse;
                y <= y_mouse;
            end
        end

        assign pos_x[32*i +: 32] = x;
        assign pos_y[32*i +: 32] = y;

`ifdef ROPE_TRACE_EN
        always @(posedge clk) begin
            if (!reset) begin
                $display("  node %0d cur=(%h,%h) new=(%h,%h)", i, x, y, relax_x, relax_y);
            end
        end
`endif
    end

`ifdef ROPE_TRACE_EN
    always @(posedge clk) begin
        if (!reset) begin
            $display("rope core %0d token=%h", CORE_ID, token);
        end
    end
`else
    // Tracing compiled out; no simulation output.
`endif

endmodule

// File: tb/tb_rope_segment_core.sv
// Directed bench: head segment (CORE_ID=1) and second segment (CORE_ID=2) run side by side from one reset.
module tb_rope_segment_core;

    localparam int N = 5;

    logic clk = 1'b0;
    logic reset;

    logic signed [31:0] prev1_x, prev1_y, next1_x, next1_y, mouse1_x, mouse1_y;
    logic signed [31:0] prev2_x, prev2_y, next2_x, next2_y, mouse2_x, mouse2_y;
    logic [N*32-1:0]    pos1_x, pos1_y, pos2_x, pos2_y;
    logic [2*N-1:0]     ctrl1, ctrl2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rope_segment_core #(.NODE_CONTAINS(N), .CORE_ID(1), .SPACING(16)) dut1 (
        .clk(clk), .reset(reset),
        .prev_core_last_x(prev1_x), .prev_core_last_y(prev1_y),
        .next_core_first_x(next1_x), .next_core_first_y(next1_y),
        .x_mouse(mouse1_x), .y_mouse(mouse1_y),
        .pos_x(pos1_x), .pos_y(pos1_y), .control_signal(ctrl1)
    );

    rope_segment_core #(.NODE_CONTAINS(N), .CORE_ID(2), .SPACING(16)) dut2 (
        .clk(clk), .reset(reset),
        .prev_core_last_x(prev2_x), .prev_core_last_y(prev2_y),
        .next_core_first_x(next2_x), .next_core_first_y(next2_y),
        .x_mouse(mouse2_x), .y_mouse(mouse2_y),
        .pos_x(pos2_x), .pos_y(pos2_y), .control_signal(ctrl2)
    );

    typedef struct {
        int ctrl;
        int n0x, n0y, n1x, n1y;
        int m2x;
        int d2x0;
    } vec_t;

    vec_t vecs[12];

    function automatic int node(input logic [N*32-1:0] v, input int i);
        return int'($signed(v[32*i +: 32]));
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " ctrl1"}, longint'(ctrl1), 1);
        check({tag, " ctrl2"}, longint'(ctrl2), 1);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s d1 x%0d", tag, i), node(pos1_x, i), i * 16);
            check($sformatf("%s d1 y%0d", tag, i), node(pos1_y, i), 0);
            check($sformatf("%s d2 x%0d", tag, i), node(pos2_x, i), (N + i) * 16);
            check($sformatf("%s d2 y%0d", tag, i), node(pos2_y, i), 0);
        end
    endtask

    initial begin
        // Edge k after release acts on token bit (k-1)%10; node0 takes mouse at edge 6, node1 relaxes at edge 12.
        vecs[0]  = '{2,   0,  0, 16,  0, 1001, 80};
        vecs[1]  = '{4,   0,  0, 16,  0, 1002, 80};
        vecs[2]  = '{8,   0,  0, 16,  0, 1003, 80};
        vecs[3]  = '{16,  0,  0, 16,  0, 1004, 80};
        vecs[4]  = '{32,  0,  0, 16,  0, 1005, 80};
        vecs[5]  = '{64,  100, 50, 16, 0, 1006, 80};
        vecs[6]  = '{128, 100, 50, 16, 0, 1007, 80};
        vecs[7]  = '{256, 100, 50, 16, 0, 1008, 80};
        vecs[8]  = '{512, 100, 50, 16, 0, 1009, 80};
        vecs[9]  = '{1,   100, 50, 16, 0, 1010, 80};
        vecs[10] = '{2,   100, 50, 16, 0, 1011, 80};
        vecs[11] = '{4,   100, 50, 41, 12, 1012, 80};

        reset    = 1'b1;
        prev1_x  = 0;   prev1_y  = 0;   next1_x  = 80;  next1_y  = 0;
        mouse1_x = 100; mouse1_y = 50;
        prev2_x  = 64;  prev2_y  = 0;   next2_x  = 160; next2_y  = 0;
        mouse2_x = 999; mouse2_y = -999;

        #12;
        check_reset_state("reset");

        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 12; k++) begin
            mouse2_x = vecs[k].m2x;
            mouse2_y = -vecs[k].m2x;
            step();
            check($sformatf("edge%0d ctrl", k + 1), longint'(ctrl1), vecs[k].ctrl);
            check($sformatf("edge%0d d1 n0x", k + 1), node(pos1_x, 0), vecs[k].n0x);
            check($sformatf("edge%0d d1 n0y", k + 1), node(pos1_y, 0), vecs[k].n0y);
            check($sformatf("edge%0d d1 n1x", k + 1), node(pos1_x, 1), vecs[k].n1x);
            check($sformatf("edge%0d d1 n1y", k + 1), node(pos1_y, 1), vecs[k].n1y);
            check($sformatf("edge%0d d2 n0x", k + 1), node(pos2_x, 0), vecs[k].d2x0);
            check($sformatf("edge%0d d2 n0y", k + 1), node(pos2_y, 0), 0);
        end
        for (int i = 2; i < N; i++) begin
            check($sformatf("edge12 d1 x%0d", i), node(pos1_x, i), i * 16);
        end

        // Negative neighbour: (-100 + 160 + 96) >>> 2 = 39, (-7) >>> 2 = -2 (floor).
        prev2_x = -100;
        prev2_y = -7;
        repeat (8) step();
        check("edge20 d2 n0x held", node(pos2_x, 0), 80);
        step();
        check("edge21 ctrl", longint'(ctrl2), 2);
        check("edge21 d2 n0x neg", node(pos2_x, 0), 39);
        check("edge21 d2 n0y neg", node(pos2_y, 0), -2);

        // Asynchronous reset between edges must clear everything before the next edge.
        step();
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("async");
        @(negedge clk);
        reset = 1'b0;
        step();
        check("post-reset ctrl1", longint'(ctrl1), 2);
        check("post-reset d1 n0x", node(pos1_x, 0), 0);
        check("post-reset d2 n0x", node(pos2_x, 0), 39);
        check("post-reset d2 n0y", node(pos2_y, 0), -2);
        check("post-reset d2 n1x", node(pos2_x, 1), 96);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rope_segment_core.md
ROPE_SEGMENT_CORE -- requirements
Module: rope_segment_core

Interface
REQ-001 Parameter NODE_CONTAINS, default 5, number of rope nodes in this segment (>=2).
REQ-002 Parameter CORE_ID, default 1, 1-based segment index in the rope; CORE_ID==1 marks the mouse-anchored head segment.
REQ-003 Parameter SPACING, default 16, reset distance between adjacent nodes along x.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 prev_core_last_x / prev_core_last_y  input  32 each  position of the previous segment's last node (signed).
REQ-007 next_core_first_x / next_core_first_y  input  32 each  position of the next segment's first node (signed).
REQ-008 x_mouse / y_mouse  input  32 each  mouse target position (signed).
REQ-009 pos_x / pos_y  output  NODE_CONTAINS*32 each  node positions, node i at bits [32i+31:32i].
REQ-010 control_signal  output  2*NODE_CONTAINS  current one-hot token.

Function
REQ-011 Token register (2*NODE_CONTAINS bits) shall rotate left by one every clock when not in reset (MSB wraps to bit 0); period 2*NODE_CONTAINS cycles.
REQ-012 Node i shall receive relax strobe = token bit i and mouse strobe = token bit i+NODE_CONTAINS, sampled from the current (pre-rotation) token.
REQ-013 Constraint function for (prev, cur, next), per axis: new = (prev + 2*cur + next) >>> 2, 34-bit signed intermediate, arithmetic shift, truncated to 32 bits.
REQ-014 Node i neighbours: prev = node i-1 (node 0 uses prev_core_last), next = node i+1 (last node uses next_core_first).
REQ-015 When CORE_ID==1, node 0 shall bypass the constraint (new = cur).
REQ-016 On relax strobe, node i shall load its constraint result; otherwise hold.
REQ-017 On mouse strobe, node 0 shall load (x_mouse, y_mouse) only if CORE_ID==1; all other nodes ignore the mouse strobe.
REQ-018 Strobes are one-hot, so at most one node updates per cycle; all updates use positions registered before the edge.
REQ-019 Outputs are registered values directly; no combinational input-to-output path except none.

Reset
REQ-020 While reset is high: token = 1 (bit 0), node i position x = ((CORE_ID-1)*NODE_CONTAINS + i)*SPACING, y = 0.
REQ-021 Reset asserted mid-rotation shall clear token and positions immediately, regardless of clk.
REQ-022 First rising edge after reset release shall act on token bit 0.

Configuration
REQ-023 Macro ROPE_TRACE_EN: when defined, each non-reset rising edge shall print the token and, per node, current and constraint-result x/y in hex; when undefined, no printing; RTL behaviour is identical either way.

Verification (NODE_CONTAINS=5, SPACING=16)
REQ-024 Reset, CORE_ID=1 -> control_signal=1, pos_x = {64,48,32,16,0}, all pos_y=0.
REQ-025 Release reset, 10 clocks -> control_signal returns to 1, passing 2,4,...,512 in order.
REQ-026 CORE_ID=1, mouse=(100,50), 6 clocks after release -> node0=(100,50), other nodes unchanged (straight line is a constraint fixed point).
REQ-027 Continue 6 more clocks (token bit 1 hits, from REQ-026) -> node1 = (41,12).
REQ-028 CORE_ID=2, prev_core_last=(64,0), mouse changes -> node0 never takes mouse; relax at bit 0 with node0 (80,0), node1 (96,0) -> stays (80,0).
REQ-029 Assert reset asynchronously between clk edges mid-sequence -> outputs return to REQ-024 values before next edge.
